// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetches and decodes ROM instructions, drives datapath control and branches on latched N/Z/C
module datapath_sequencer #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  input  logic            N,
  input  logic            Z,
  input  logic            C,
  output logic            WE,
  output logic [2:0]      W_Adr,
  output logic [2:0]      R_Adr,
  output logic [2:0]      S_Adr,
  output logic            S_Sel,
  output logic [3:0]      Alu_Op,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      flags,
  output logic            busy,
  output logic            done
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED} state_t;
  localparam logic [3:0] OP_BRZ = 4'd13;
  localparam logic [3:0] OP_JMP = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, target, pc_inc;
  logic [15:0] ir_q, ir_d;
  logic [2:0] flags_q, flags_d;
  logic [3:0] op;
  logic is_alu, ctl_en, unused_ok;
  assign op = ir_q[15:12];
  assign is_alu = op <= 4'd12;
  assign target = PC_W'(ir_q[7:0]);
  assign pc_inc = pc_q + PC_W'(1);
  assign unused_ok = ir_q[0];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        pc_d = start ? START_PC : pc_q;
        state_d = start ? FETCH : IDLE;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d = instr_data;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        state_d = is_alu ? WRITEBACK : (op == OP_HALT) ? HALTED : FETCH;
        // BRZ looks only at the Z latched by the last writeback
        pc_d = (op == OP_JMP) ? target : (op == OP_BRZ) ? (flags_q[1] ? target : pc_inc) : pc_q;
      end
      WRITEBACK: begin
        flags_d = {N, Z, C};
        pc_d = pc_inc;
        state_d = FETCH;
      end
      HALTED: state_d = start ? HALTED : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= START_PC;
      ir_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      flags_q <= flags_d;
    end
  end
  assign ctl_en = is_alu && (state_q == EXECUTE || state_q == WRITEBACK);
  assign Alu_Op = ctl_en ? op : '0;
  assign W_Adr = ctl_en ? ir_q[11:9] : '0;
  assign R_Adr = ctl_en ? ir_q[8:6] : '0;
  assign S_Adr = ctl_en ? ir_q[5:3] : '0;
  assign S_Sel = ctl_en && ir_q[2];
  assign WE = (state_q == WRITEBACK) && ir_q[1];
  assign instr_addr = pc_q;
  assign pc = pc_q;
  assign flags = flags_q;
  assign busy = state_q inside {FETCH, DECODE, EXECUTE, WRITEBACK};
  assign done = state_q == HALTED;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed plus random programs checked against an instruction-level model
module tb_datapath_sequencer;
  localparam int PC_W = 8;
  logic clk = 1'b0;
  logic reset, start;
  logic [PC_W-1:0] instr_addr, pc;
  logic [15:0] instr_data;
  logic N, Z, C, WE, S_Sel, busy, done;
  logic [2:0] W_Adr, R_Adr, S_Adr, flags;
  logic [3:0] Alu_Op;
  logic [15:0] rom [256];
  int n_pass = 0;
  int n_chk = 0;
  logic [7:0] m_pc;
  logic [2:0] m_flags;
  bit rand_start = 0;
  bit h;

  datapath_sequencer #(.PC_W(PC_W), .START_PC('0)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr), .instr_data(instr_data),
    .N(N), .Z(Z), .C(C), .WE(WE), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel),
    .Alu_Op(Alu_Op), .pc(pc), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) instr_data <= rom[instr_addr];

  // stand-in datapath: flags are a fixed function of the control word
  function automatic logic [2:0] dp_flags(input logic [3:0] op, input logic [2:0] r, input logic [2:0] s, input logic ssel);
    return {op[2] ^ r[0], r == s, ssel ^ op[3]};
  endfunction
  assign {N, Z, C} = dp_flags(Alu_Op, R_Adr, S_Adr, S_Sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_start) start = 1'($urandom);
  endtask

  // called one step after entering FETCH; returns after the instruction completes
  task automatic exec_one(output bit halted);
    logic [15:0] w;
    logic [3:0] op;
    w = rom[m_pc];
    op = w[15:12];
    halted = 0;
    chk("fetch_addr", 32'(instr_addr), 32'(m_pc));
    chk("fetch_state", {busy, done, WE, Alu_Op}, {3'b100, 4'd0});
    tick();
    chk("decode_ctl", {busy, WE, W_Adr, R_Adr, S_Adr, S_Sel, Alu_Op}, {1'b1, 15'd0});
    tick();
    if (op <= 4'd12) chk("exec_ctl", {busy, WE, W_Adr, R_Adr, S_Adr, S_Sel, Alu_Op}, {2'b10, w[11:2], op});
    else chk("exec_br_ctl", {busy, WE, Alu_Op}, 6'b100000);
    if (op <= 4'd12) begin
      tick();
      chk("wb_ctl", {busy, WE, W_Adr, R_Adr, S_Adr, S_Sel, Alu_Op}, {1'b1, w[1], w[11:2], op});
      m_flags = dp_flags(op, w[8:6], w[5:3], w[2]);
      m_pc = m_pc + 8'd1;
    end else if (op == 4'd13) m_pc = m_flags[1] ? w[7:0] : m_pc + 8'd1;
    else if (op == 4'd14) m_pc = w[7:0];
    else halted = 1;
    tick();
    if (halted) chk("halt_state", {busy, done, WE, pc}, {3'b010, m_pc});
    else chk("next_fetch", {busy, done, WE, pc, instr_addr, flags}, {3'b100, m_pc, m_pc, m_flags});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    rom[0] = 16'h4A1A;
    rom[1] = 16'h6090;
    rom[2] = 16'hD010;
    rom[3] = 16'hE0FF;
    rom[8'hFF] = 16'h424A;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {busy, done, WE, W_Adr, R_Adr, S_Adr, S_Sel, Alu_Op}, 0);
    chk("reset_pc", {pc, instr_addr, flags}, 0);
    reset = 1'b1;
    tick();
    m_pc = 0;
    m_flags = 0;
    exec_one(h);
    chk("alu_pc", 32'(pc), 1);
    exec_one(h);
    exec_one(h);
    chk("brz_taken_pc", 32'(pc), 32'h10);
    exec_one(h);
    chk("halted", {h, done, busy, pc}, {3'b110, 8'h10});
    repeat (3) begin
      tick();
      chk("halt_hold", {done, busy, pc}, {2'b10, 8'h10});
    end
    start = 1'b0;
    tick();
    chk("halt_to_idle", {done, busy}, 0);
    rom[1] = 16'h6098;
    start = 1'b1;
    tick();
    chk("restart_fetch", {busy, instr_addr, pc}, {1'b1, 8'h0, 8'h0});
    m_pc = 0;
    exec_one(h);
    exec_one(h);
    exec_one(h);
    chk("brz_not_taken_pc", 32'(pc), 3);
    exec_one(h);
    chk("jmp_pc", 32'(pc), 32'hFF);
    exec_one(h);
    chk("wrap_pc", {pc, instr_addr, flags}, {8'h00, 8'h00, 3'b010});
    tick();
    tick();
    tick();
    chk("wb_we", 32'(WE), 1);
    reset = 1'b0;
    tick();
    chk("rst_wb_ctl", {busy, done, WE, W_Adr, R_Adr, S_Adr, S_Sel, Alu_Op}, 0);
    chk("rst_wb_state", {pc, instr_addr, flags}, 0);
    reset = 1'b1;
    start = 1'b0;
    tick();
    chk("idle_hold", {busy, done, WE}, 0);
    for (int i = 0; i < 256; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 19);
      op = (r < 13) ? 4'(r) : (r < 16) ? 4'd13 : (r < 18) ? 4'd14 : (r == 18) ? 4'd15 : 4'd4;
      rom[i] = {op, 12'($urandom)};
    end
    start = 1'b1;
    tick();
    m_pc = 0;
    m_flags = 0;
    rand_start = 1;
    for (int i = 0; i < 300; i++) begin
      exec_one(h);
      if (h) begin
        rand_start = 0;
        start = 1'b1;
        tick();
        chk("rnd_halt_hold", {done, busy, pc}, {2'b10, m_pc});
        start = 1'b0;
        tick();
        chk("rnd_halt_idle", {done, busy}, 0);
        start = 1'b1;
        tick();
        m_pc = 0;
        rand_start = 1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
